lcd_line_sequencer: RTL

- Scanline timing master that drives the whizgraphics renderer from the initiator side.
- Counts dots and lines for a 154-line Game Boy frame and walks each visible line through OAM-scan, draw and HBlank.
- Issues the `drawline` request at the start of each draw period and waits on `renderComplete` to close it.
- Publishes LY, STAT mode, the LYC compare, the VBlank and STAT interrupt pulses, and a sticky render-overrun flag.

---
 rtl/lcd_line_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/lcd_line_sequencer.sv
// Scanline timing master: counts dots/lines of a 154-line frame, sequences
// OAM -> DRAW -> HBLANK on visible lines and hands line requests to the renderer.
module lcd_line_sequencer #(
    parameter int unsigned DOTS_PER_LINE = 456,
    parameter int unsigned VISIBLE_LINES = 144,
    parameter int unsigned TOTAL_LINES   = 154,
    parameter int unsigned OAM_DOTS      = 80,
    parameter int unsigned MIN_DRAW_DOTS = 172
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       lcd_enable,
    input  logic [7:0] lyc,
    input  logic       render_complete,
    input  logic       overrun_clr,
    output logic       drawline,
    output logic [7:0] draw_ly,
    output logic [7:0] ly,
    output logic [8:0] dot,
    output logic [1:0] mode,
    output logic       lyc_match,
    output logic       vblank_irq,
    output logic       stat_irq,
    output logic       frame_done,
    output logic       overrun
);

    localparam int unsigned DOT_W = 9;
    localparam int unsigned LY_W  = 8;

    localparam logic [DOT_W-1:0] LAST_DOT       = DOT_W'(DOTS_PER_LINE - 1);
    localparam logic [DOT_W-1:0] LAST_OAM_DOT   = DOT_W'(OAM_DOTS - 1);
    localparam logic [DOT_W-1:0] FIRST_RC_DOT   = DOT_W'(OAM_DOTS + 1);
    localparam logic [DOT_W-1:0] MIN_HBLANK_DOT = DOT_W'(OAM_DOTS + MIN_DRAW_DOTS);
    localparam logic [LY_W-1:0]  LAST_LINE      = LY_W'(TOTAL_LINES - 1);
    localparam logic [LY_W-1:0]  VBLANK_LINE    = LY_W'(VISIBLE_LINES);

    localparam logic [1:0] MODE_HBLANK = 2'd0;
    localparam logic [1:0] MODE_VBLANK = 2'd1;
    localparam logic [1:0] MODE_OAM    = 2'd2;
    localparam logic [1:0] MODE_DRAW   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OAM,
        ST_DRAW,
        ST_HBLANK,
        ST_VBLANK
    } state_e;

    state_e             state_q, state_d;
    logic [DOT_W-1:0]   dot_q, dot_d;
    logic [LY_W-1:0]    ly_q, ly_d;
    logic [1:0]         mode_q, mode_d;
    logic               done_q, done_d;
    logic               drawline_q, drawline_d;
    logic [LY_W-1:0]    draw_ly_q, draw_ly_d;
    logic               lyc_match_q, lyc_match_d;
    logic               vblank_irq_q, vblank_irq_d;
    logic               stat_irq_q, stat_irq_d;
    logic               frame_done_q, frame_done_d;
    logic               overrun_q, overrun_d;
    logic               line_end;
    logic               ov_set;

    // Next-state: counters, line phase, pulses and sticky overrun
    always_comb begin
        state_d      = state_q;
        dot_d        = dot_q;
        ly_d         = ly_q;
        done_d       = done_q;
        drawline_d   = 1'b0;
        draw_ly_d    = draw_ly_q;
        vblank_irq_d = 1'b0;
        frame_done_d = 1'b0;
        line_end     = 1'b0;
        ov_set       = 1'b0;

        if (!lcd_enable) begin
            state_d = ST_IDLE;
            dot_d   = '0;
            ly_d    = '0;
            done_d  = 1'b0;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_OAM;
            dot_d   = '0;
            ly_d    = '0;
            done_d  = 1'b0;
        end else begin
            line_end = (dot_q == LAST_DOT);
            dot_d    = line_end ? '0 : dot_q + DOT_W'(1);

            case (state_q)
                ST_OAM: begin
                    if (dot_q == LAST_OAM_DOT) begin
                        state_d    = ST_DRAW;
                        drawline_d = 1'b1;
                        draw_ly_d  = ly_q;
                        done_d     = 1'b0;
                    end
                end
                ST_DRAW: begin
                    // Completion is latched; DRAW still lasts at least MIN_DRAW_DOTS
                    done_d = done_q | (render_complete && (dot_q >= FIRST_RC_DOT));
                    if (done_d && (dot_d >= MIN_HBLANK_DOT)) begin
                        state_d = ST_HBLANK;
                    end
                    ov_set = line_end;
                end
                default: ;
            endcase

            if (line_end) begin
                ly_d         = (ly_q == LAST_LINE) ? '0 : ly_q + LY_W'(1);
                state_d      = (ly_d < VBLANK_LINE) ? ST_OAM : ST_VBLANK;
                done_d       = 1'b0;
                vblank_irq_d = (ly_d == VBLANK_LINE);
                frame_done_d = (ly_q == LAST_LINE);
            end
        end

        lyc_match_d = lcd_enable && (ly_d == lyc);
        stat_irq_d  = lyc_match_d && !lyc_match_q;
        overrun_d   = ov_set | (overrun_q & ~overrun_clr);

        case (state_d)
            ST_OAM:    mode_d = MODE_OAM;
            ST_DRAW:   mode_d = MODE_DRAW;
            ST_VBLANK: mode_d = MODE_VBLANK;
            default:   mode_d = MODE_HBLANK;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            dot_q        <= '0;
            ly_q         <= '0;
            mode_q       <= MODE_HBLANK;
            done_q       <= 1'b0;
            drawline_q   <= 1'b0;
            draw_ly_q    <= '0;
            lyc_match_q  <= 1'b0;
            vblank_irq_q <= 1'b0;
            stat_irq_q   <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            dot_q        <= dot_d;
            ly_q         <= ly_d;
            mode_q       <= mode_d;
            done_q       <= done_d;
            drawline_q   <= drawline_d;
            draw_ly_q    <= draw_ly_d;
            lyc_match_q  <= lyc_match_d;
            vblank_irq_q <= vblank_irq_d;
            stat_irq_q   <= stat_irq_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign drawline   = drawline_q;
    assign draw_ly    = draw_ly_q;
    assign ly         = ly_q;
    assign dot        = dot_q;
    assign mode       = mode_q;
    assign lyc_match  = lyc_match_q;
    assign vblank_irq = vblank_irq_q;
    assign stat_irq   = stat_irq_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule
